// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: shares one settings-register access port between NUM_REQ
// requesters with round-robin arbitration and one transaction in flight.
// Each transaction is IDLE -> ISSUE -> DONE. ack pulses for one cycle in DONE
// and carries rdata and rd_err.
// Optional feature: define REG_PORT_ARB_RDBACK_EN to follow every write with a
// one-cycle VERIFY readback that compares the port data against the written
// value and reports the result on rd_err.
module reg_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rd_err,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic [1:0]                reg_enable,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [DATA_W-1:0]         reg_datain,
  input  logic [DATA_W-1:0]         reg_dataout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
`ifdef REG_PORT_ARB_RDBACK_EN
  localparam logic [1:0] VERIFY = 2'd3;
`endif

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [1:0]         r_rr_ptr;
  logic               r_we;
  logic [NUM_REQ-1:0] r_ack;
  logic [DATA_W-1:0]  r_rdata;
  logic [1:0]         r_grant_id;
  logic               r_busy;
  logic [1:0]         r_reg_enable;
  logic [ADDR_W-1:0]  r_reg_addr;
  logic [DATA_W-1:0]  r_reg_datain;

  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
  logic [2:0]         w_scan_idx;
  logic               w_pick_valid;
  logic [1:0]         w_pick_id;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [1:0]         w_rr_next;

  // Unpack the flat per-requester address and data buses
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: scan offsets from the far end down to 0 so the requester
  // closest to rr_ptr (at or after it, wrapping) is the one left selected
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = 2'd0;
    w_scan_idx   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = {1'b0, r_rr_ptr} + 3'(k);
      if (w_scan_idx >= 3'(NUM_REQ)) begin
        w_scan_idx = w_scan_idx - 3'(NUM_REQ);
      end
      if ((req & (ONE_HOT0 << w_scan_idx)) != '0) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_scan_idx[1:0];
      end
    end
  end

  // Mux out the chosen requester's transaction fields
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_id == 2'(k)) begin
        w_sel_we    = req_we[k];
        w_sel_addr  = w_addr_arr[k];
        w_sel_wdata = w_wdata_arr[k];
      end
    end
  end

  // Pointer moves to the requester after the one just served
  assign w_rr_next = (r_grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : r_grant_id + 2'd1;

  // Transaction FSM; every output is a register loaded on the edge that enters
  // the state in which it must be visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 2'd0;
      r_we         <= 1'b0;
      r_ack        <= '0;
      r_rdata      <= '0;
      r_grant_id   <= 2'd0;
      r_busy       <= 1'b0;
      r_reg_enable <= 2'b00;
      r_reg_addr   <= '0;
      r_reg_datain <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state      <= ISSUE;
            r_busy       <= 1'b1;
            r_grant_id   <= w_pick_id;
            r_we         <= w_sel_we;
            r_reg_addr   <= w_sel_addr;
            r_reg_datain <= w_sel_wdata;
            r_reg_enable <= {1'b1, ~w_sel_we};
          end
        end
        ISSUE: begin
          if (!r_we) begin
            r_rdata <= reg_dataout;
          end
`ifdef REG_PORT_ARB_RDBACK_EN
          if (r_we) begin
            r_state      <= VERIFY;
            r_reg_enable <= 2'b11;
          end else begin
            r_state      <= DONE;
            r_reg_enable <= 2'b00;
            r_ack        <= ONE_HOT0 << r_grant_id;
          end
`else
          r_state      <= DONE;
          r_reg_enable <= 2'b00;
          r_ack        <= ONE_HOT0 << r_grant_id;
`endif
        end
`ifdef REG_PORT_ARB_RDBACK_EN
        VERIFY: begin
          r_rdata      <= reg_dataout;
          r_state      <= DONE;
          r_reg_enable <= 2'b00;
          r_ack        <= ONE_HOT0 << r_grant_id;
        end
`endif
        DONE: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_rr_next;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_reg_enable <= 2'b00;
        end
      endcase
    end
  end

`ifdef REG_PORT_ARB_RDBACK_EN
  logic r_rd_err;

  // Readback verdict is loaded with the ack and cleared once DONE is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_err <= 1'b0;
    end else if (r_state == VERIFY) begin
      r_rd_err <= (reg_dataout != r_reg_datain);
    end else if (r_state == DONE) begin
      r_rd_err <= 1'b0;
    end
  end

  assign rd_err = r_rd_err;
`else
  assign rd_err = 1'b0;
`endif

  assign ack        = r_ack;
  assign rdata      = r_rdata;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign reg_enable = r_reg_enable;
  assign reg_addr   = r_reg_addr;
  assign reg_datain = r_reg_datain;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter: directed bench for reg_port_arbiter with a small model
// of the settings port (threshhold at 51, rssi_wait at 52, 0xFFFFFFFF elsewhere).
module tb_reg_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   ack;
  logic [DW-1:0]   rdata;
  logic            rd_err;
  logic [1:0]      grant_id;
  logic            busy;
  logic [1:0]      reg_enable;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_datain;
  logic [DW-1:0]   reg_dataout;

  logic [DW-1:0]   thr_q = '0;
  logic [DW-1:0]   rssi_q = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .rd_err(rd_err),
    .grant_id(grant_id), .busy(busy), .reg_enable(reg_enable), .reg_addr(reg_addr),
    .reg_datain(reg_datain), .reg_dataout(reg_dataout)
  );

  always #5 clk = ~clk;

  // Settings port model: write strobe captures at the closing edge
  always @(posedge clk) begin
    if (reg_enable == 2'b10) begin
      if (reg_addr == 7'd51) thr_q <= reg_datain;
      else if (reg_addr == 7'd52) rssi_q <= reg_datain;
    end
  end

  assign reg_dataout = (reg_addr == 7'd51) ? thr_q :
                       (reg_addr == 7'd52) ? rssi_q : 32'hFFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[id] = 1'b1;
    req_we[id] = we;
    req_addr[int'(id)*AW +: AW] = a;
    req_wdata[int'(id)*DW +: DW] = d;
  endtask

  // Stimulus-only transaction with a bounded wait for its ack
  task automatic run_quiet(input logic id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    drive(id, we, a, d);
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (ack[id]) got = 1;
    end
    total_cnt++;
    if (!got) $display("FAIL quiet_ack_timeout got none required ack[%0d]", id);
    else pass_cnt++;
    req[id] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    total_cnt++; if (ack !== 2'b00) $display("FAIL rst_ack got %b required 00", ack); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (reg_enable !== 2'b00) $display("FAIL rst_enable got %b required 00", reg_enable); else pass_cnt++;
    total_cnt++;
    if ({rdata, rd_err, grant_id, reg_addr, reg_datain} !== '0)
      $display("FAIL rst_outputs got rdata=%h err=%b gid=%0d addr=%0d din=%h required all 0", rdata, rd_err, grant_id, reg_addr, reg_datain);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    drive(0, 1'b1, 7'd51, 32'h0000_1234);
    tick();
    total_cnt++; if (reg_enable !== 2'b10) $display("FAIL wr_issue_enable got %b required 10", reg_enable); else pass_cnt++;
    total_cnt++; if (reg_addr !== 7'd51) $display("FAIL wr_issue_addr got %0d required 51", reg_addr); else pass_cnt++;
    total_cnt++; if (reg_datain !== 32'h0000_1234) $display("FAIL wr_issue_data got %h required 00001234", reg_datain); else pass_cnt++;
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL wr_issue_gid got %0d required 0", grant_id); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL wr_issue_busy got %b required 1", busy); else pass_cnt++;
    total_cnt++; if (ack !== 2'b00) $display("FAIL wr_issue_ack got %b required 00", ack); else pass_cnt++;
`ifdef REG_PORT_ARB_RDBACK_EN
    tick();
    total_cnt++; if (reg_enable !== 2'b11) $display("FAIL wr_verify_enable got %b required 11", reg_enable); else pass_cnt++;
`endif
    tick();
    total_cnt++; if (ack !== 2'b01) $display("FAIL wr_ack got %b required 01", ack); else pass_cnt++;
    total_cnt++; if (rd_err !== 1'b0) $display("FAIL wr_rd_err got %b required 0", rd_err); else pass_cnt++;
    total_cnt++; if (reg_enable !== 2'b00) $display("FAIL wr_done_enable got %b required 00", reg_enable); else pass_cnt++;
    req[0] = 1'b0;
    tick();
    total_cnt++; if ({ack, busy} !== 3'b000) $display("FAIL wr_idle got ack=%b busy=%b required 00/0", ack, busy); else pass_cnt++;
    total_cnt++; if (thr_q !== 32'h0000_1234) $display("FAIL wr_thr_value got %h required 00001234", thr_q); else pass_cnt++;
  endtask

  task automatic test_read();
    run_quiet(1, 1'b1, 7'd52, 32'hDEAD_BEEF);
    drive(1, 1'b0, 7'd52, 32'h0);
    tick();
    total_cnt++; if (reg_enable !== 2'b11) $display("FAIL rd_issue_enable got %b required 11", reg_enable); else pass_cnt++;
    total_cnt++; if (grant_id !== 2'd1) $display("FAIL rd_issue_gid got %0d required 1", grant_id); else pass_cnt++;
    tick();
    total_cnt++; if (ack !== 2'b10) $display("FAIL rd_ack got %b required 10", ack); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h required deadbeef", rdata); else pass_cnt++;
    total_cnt++; if (rd_err !== 1'b0) $display("FAIL rd_err got %b required 0", rd_err); else pass_cnt++;
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack;
    logic [1:0]  exp_gid;
    logic [31:0] exp_data;
    drive(0, 1'b0, 7'd51, 32'h0);
    drive(1, 1'b0, 7'd52, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_gid  = ((c / 3) % 2 == 0) ? 2'd0 : 2'd1;
      exp_data = (exp_gid == 2'd0) ? 32'h0000_1234 : 32'hDEAD_BEEF;
      exp_ack  = (c % 3 == 2) ? ((exp_gid == 2'd0) ? 2'b01 : 2'b10) : 2'b00;
      total_cnt++;
      if (ack !== exp_ack) $display("FAIL rr_ack_c%0d got %b required %b", c, ack, exp_ack); else pass_cnt++;
      if (c % 3 == 1) begin
        total_cnt++;
        if (grant_id !== exp_gid) $display("FAIL rr_gid_c%0d got %0d required %0d", c, grant_id, exp_gid); else pass_cnt++;
      end
      if (c % 3 == 2) begin
        total_cnt++;
        if (rdata !== exp_data) $display("FAIL rr_rdata_c%0d got %h required %h", c, rdata, exp_data); else pass_cnt++;
      end
    end
    req = 2'b00;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rr_end_busy got %b required 0", busy); else pass_cnt++;
  endtask

  task automatic test_oob_read();
    drive(0, 1'b0, 7'd60, 32'h0);
    tick();
    total_cnt++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL oob_rdata_hold got %h required deadbeef", rdata); else pass_cnt++;
    req[0] = 1'b0;
    tick();
    total_cnt++; if (ack !== 2'b01) $display("FAIL oob_ack got %b required 01", ack); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL oob_rdata got %h required ffffffff", rdata); else pass_cnt++;
    tick(); tick();
    total_cnt++; if ({busy, ack} !== 3'b000) $display("FAIL oob_no_retrigger got busy=%b ack=%b required 0/00", busy, ack); else pass_cnt++;
  endtask

  task automatic test_write_keeps_rdata();
    logic [31:0] exp_data;
`ifdef REG_PORT_ARB_RDBACK_EN
    exp_data = 32'h0000_00A5;
`else
    exp_data = 32'hFFFF_FFFF;
`endif
    drive(1, 1'b1, 7'd52, 32'h0000_00A5);
    tick();
`ifdef REG_PORT_ARB_RDBACK_EN
    tick();
`endif
    tick();
    total_cnt++; if (ack !== 2'b10) $display("FAIL wk_ack got %b required 10", ack); else pass_cnt++;
    total_cnt++; if (rdata !== exp_data) $display("FAIL wk_rdata got %h required %h", rdata, exp_data); else pass_cnt++;
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    run_quiet(0, 1'b0, 7'd51, 32'h0);
    drive(0, 1'b1, 7'd51, 32'h0000_7777);
    tick();
    total_cnt++; if (reg_enable !== 2'b10) $display("FAIL mr_issue_enable got %b required 10", reg_enable); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({ack, rdata, rd_err, grant_id, busy, reg_enable, reg_addr, reg_datain} !== '0)
      $display("FAIL mr_async_clear got ack=%b rdata=%h gid=%0d busy=%b en=%b required all 0", ack, rdata, grant_id, busy, reg_enable);
    else pass_cnt++;
    tick();
    total_cnt++; if (ack !== 2'b00) $display("FAIL mr_no_ack got %b required 00", ack); else pass_cnt++;
    total_cnt++; if (thr_q !== 32'h0000_1234) $display("FAIL mr_write_abandoned got %h required 00001234", thr_q); else pass_cnt++;
    reset = 1'b0;
    drive(0, 1'b0, 7'd51, 32'h0);
    drive(1, 1'b0, 7'd52, 32'h0);
    tick();
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL mr_rr_restart got %0d required 0", grant_id); else pass_cnt++;
    tick();
    total_cnt++; if (ack !== 2'b01) $display("FAIL mr_ack got %b required 01", ack); else pass_cnt++;
    req = 2'b00;
    tick(); tick();
  endtask

`ifdef REG_PORT_ARB_RDBACK_EN
  task automatic test_rdback();
    drive(0, 1'b1, 7'd60, 32'h0000_0005);
    tick();
    tick();
    total_cnt++; if (reg_enable !== 2'b11) $display("FAIL rb_verify_enable got %b required 11", reg_enable); else pass_cnt++;
    tick();
    total_cnt++; if (ack !== 2'b01) $display("FAIL rb_ack got %b required 01", ack); else pass_cnt++;
    total_cnt++; if (rd_err !== 1'b1) $display("FAIL rb_err_bad got %b required 1", rd_err); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL rb_rdata got %h required ffffffff", rdata); else pass_cnt++;
    req[0] = 1'b0;
    tick();
    drive(0, 1'b1, 7'd51, 32'h0000_0042);
    tick(); tick(); tick();
    total_cnt++; if (ack !== 2'b01) $display("FAIL rb_ack2 got %b required 01", ack); else pass_cnt++;
    total_cnt++; if (rd_err !== 1'b0) $display("FAIL rb_err_good got %b required 0", rd_err); else pass_cnt++;
    req[0] = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_oob_read();
    test_write_keeps_rdata();
    test_reset_midflight();
`ifdef REG_PORT_ARB_RDBACK_EN
    test_rdback();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
